// File: rtl/video_timing_pkg.sv
// Shared raster definitions for the display timing path: region encoding,
// 720p60 default mode constants and the position-to-region helper.
package video_timing;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } region_t;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int H_FRONT_DEF  = 72;
  localparam int H_SYNC_DEF   = 80;
  localparam int H_BACK_DEF   = 216;
  localparam int V_ACTIVE_DEF = 720;
  localparam int V_FRONT_DEF  = 3;
  localparam int V_SYNC_DEF   = 5;
  localparam int V_BACK_DEF   = 22;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Regions are laid out in order ACTIVE, FRONT, SYNC, BACK along each axis.
  function automatic region_t region_of(input int pos, input int active_len,
                                        input int front_len, input int sync_len);
    if (pos < active_len) return ACTIVE;
    if (pos < active_len + front_len) return FRONT;
    if (pos < active_len + front_len + sync_len) return SYNC;
    return BACK;
  endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: a wrapping position counter that also reports the region
// of the position it will present after the current edge.
module timing_axis_counter
  import video_timing::*;
#(
  parameter int  ACTIVE_LEN = H_ACTIVE_DEF,
  parameter int  FRONT_LEN  = H_FRONT_DEF,
  parameter int  SYNC_LEN   = H_SYNC_DEF,
  parameter int  BACK_LEN   = H_BACK_DEF,
  localparam int TOTAL      = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN,
  localparam int CW         = $clog2(TOTAL)
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] count,
  output region_t       region_next,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  assign wrap = step && (count_reg == LAST);

  always_comb begin
    count_next = count_reg;
    if (step) begin
      count_next = wrap ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Region is looked up on the next position so the registered sync/de bits
  // land on the same edge as the count they describe.
  assign region_next = region_of(int'(count_next), ACTIVE_LEN, FRONT_LEN, SYNC_LEN);
  assign count       = count_reg;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator (hsync/vsync/de/coordinates, 720p60 by default).
// Optional VTG_FRAME_COUNT_EN adds a 16-bit frame_count output.
module video_timing_gen
  import video_timing::*;
#(
  parameter int  H_ACTIVE = H_ACTIVE_DEF,
  parameter int  H_FRONT  = H_FRONT_DEF,
  parameter int  H_SYNC   = H_SYNC_DEF,
  parameter int  H_BACK   = H_BACK_DEF,
  parameter int  V_ACTIVE = V_ACTIVE_DEF,
  parameter int  V_FRONT  = V_FRONT_DEF,
  parameter int  V_SYNC   = V_SYNC_DEF,
  parameter int  V_BACK   = V_BACK_DEF,
  localparam int HW       = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK),
  localparam int VW       = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HW-1:0] hCount,
  output logic [VW-1:0] vCount,
  output logic          frame_start
`ifdef VTG_FRAME_COUNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  logic    running_reg;
  logic    hsync_reg;
  logic    vsync_reg;
  logic    de_reg;
  logic    frame_start_reg;
  logic    h_step;
  logic    h_wrap;
  logic    v_wrap;
  logic    frame_start_next;
  region_t h_region_next;
  region_t v_region_next;

  // The first enabled edge only starts the raster; (0,0) is presented
  // without advancing, so counting begins on the second enabled edge.
  assign h_step = en && running_reg;

  timing_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FRONT_LEN  (H_FRONT),
    .SYNC_LEN   (H_SYNC),
    .BACK_LEN   (H_BACK)
  ) u_h_axis (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .step        (h_step),
    .count       (hCount),
    .region_next (h_region_next),
    .wrap        (h_wrap)
  );

  timing_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FRONT_LEN  (V_FRONT),
    .SYNC_LEN   (V_SYNC),
    .BACK_LEN   (V_BACK)
  ) u_v_axis (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .step        (h_wrap),
    .count       (vCount),
    .region_next (v_region_next),
    .wrap        (v_wrap)
  );

  assign frame_start_next = !running_reg || (h_wrap && v_wrap);

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      running_reg     <= 1'b0;
      hsync_reg       <= 1'b0;
      vsync_reg       <= 1'b0;
      de_reg          <= 1'b0;
      frame_start_reg <= 1'b0;
    end else if (en) begin
      running_reg     <= 1'b1;
      hsync_reg       <= (h_region_next == SYNC);
      vsync_reg       <= (v_region_next == SYNC);
      de_reg          <= (h_region_next == ACTIVE) && (v_region_next == ACTIVE);
      frame_start_reg <= frame_start_next;
    end else begin
      frame_start_reg <= 1'b0;
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign frame_start = frame_start_reg;

`ifdef VTG_FRAME_COUNT_EN
  logic        first_seen_reg;
  logic [15:0] frame_count_reg;

  // The power-up frame is frame 0; each later frame_start bumps the count.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      first_seen_reg  <= 1'b0;
      frame_count_reg <= '0;
    end else if (en && frame_start_next) begin
      first_seen_reg <= 1'b1;
      if (first_seen_reg) begin
        frame_count_reg <= frame_count_reg + 16'd1;
      end
    end
  end

  assign frame_count = frame_count_reg;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: 720p instance for horizontal timing, a reduced mode
// (32x16 total) instance for full-frame, hold and reset behaviour.
module tb_video_timing_gen;

  logic pixel_clk = 1'b0;
  logic reset;
  logic en;

  always #5 pixel_clk = ~pixel_clk;

  // Reduced mode: H 16/4/6/6 (total 32), V 8/2/3/3 (total 16), frame = 512 edges.
  logic       s_hsync, s_vsync, s_de, s_fs;
  logic [4:0] s_h;
  logic [3:0] s_v;
  logic        f_hsync, f_vsync, f_de, f_fs;
  logic [10:0] f_h;
  logic [9:0]  f_v;
`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] s_fc;
  logic [15:0] f_fc;
`endif

  video_timing_gen #(
    .H_ACTIVE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (6),
    .V_ACTIVE (8),  .V_FRONT (2), .V_SYNC (3), .V_BACK (3)
  ) dut (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .en          (en),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .de          (s_de),
    .hCount      (s_h),
    .vCount      (s_v),
    .frame_start (s_fs)
`ifdef VTG_FRAME_COUNT_EN
    ,
    .frame_count (s_fc)
`endif
  );

  video_timing_gen dut720 (
    .pixel_clk   (pixel_clk),
    .reset       (reset),
    .en          (en),
    .hsync       (f_hsync),
    .vsync       (f_vsync),
    .de          (f_de),
    .hCount      (f_h),
    .vCount      (f_v),
    .frame_start (f_fs)
`ifdef VTG_FRAME_COUNT_EN
    ,
    .frame_count (f_fc)
`endif
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int fs_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %s: %0d at edge %0d", tag, obs, edge_n);
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
    edge_n++;
  endtask

  task automatic adv_to(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic chk_small(input string tag, input int h, input int v, input logic hs,
                           input logic vs, input logic d, input logic fs);
    chk({tag, ".h"}, 32'(s_h), h);
    chk({tag, ".v"}, 32'(s_v), v);
    chk({tag, ".hsync"}, 32'(s_hsync), 32'(hs));
    chk({tag, ".vsync"}, 32'(s_vsync), 32'(vs));
    chk({tag, ".de"}, 32'(s_de), 32'(d));
    chk({tag, ".fs"}, 32'(s_fs), 32'(fs));
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    repeat (10) tick();
    chk_small("rst", 0, 0, 0, 0, 0, 0);
    chk("rst720.de", 32'(f_de), 0);
    chk("rst720.fs", 32'(f_fs), 0);
`ifdef VTG_FRAME_COUNT_EN
    chk("rst.fc", 32'(s_fc), 0);
`endif

    // 720p horizontal timing from power-up.
    reset  = 1'b0;
    en     = 1'b1;
    edge_n = 0;
    tick();
    chk("p720_first.h", 32'(f_h), 0);
    chk("p720_first.v", 32'(f_v), 0);
    chk("p720_first.de", 32'(f_de), 1);
    chk("p720_first.fs", 32'(f_fs), 1);
    tick();
    chk("p720_e2.h", 32'(f_h), 1);
    chk("p720_e2.fs", 32'(f_fs), 0);
    adv_to(1280); chk("p720_e1280.de", 32'(f_de), 1);
    adv_to(1281); chk("p720_e1281.de", 32'(f_de), 0);
    chk("p720_e1281.h", 32'(f_h), 1280);
    adv_to(1352); chk("p720_e1352.hsync", 32'(f_hsync), 0);
    adv_to(1353); chk("p720_e1353.hsync", 32'(f_hsync), 1);
    chk("p720_e1353.h", 32'(f_h), 1352);
    adv_to(1432); chk("p720_e1432.hsync", 32'(f_hsync), 1);
    adv_to(1433); chk("p720_e1433.hsync", 32'(f_hsync), 0);
    chk("p720_e1433.vsync", 32'(f_vsync), 0);

    // Reset with en high: reset wins.
    reset = 1'b1;
    tick();
    chk_small("rst_en", 0, 0, 0, 0, 0, 0);
    reset  = 1'b0;
    edge_n = 0;
    tick();
    chk_small("s_first", 0, 0, 0, 0, 1, 1);
`ifdef VTG_FRAME_COUNT_EN
    chk("s_first.fc", 32'(s_fc), 0);
`endif
    adv_to(16);  chk_small("s_e16", 15, 0, 0, 0, 1, 0);
    adv_to(17);  chk_small("s_e17", 16, 0, 0, 0, 0, 0);
    adv_to(20);  chk_small("s_e20", 19, 0, 0, 0, 0, 0);
    adv_to(21);  chk_small("s_e21", 20, 0, 1, 0, 0, 0);
    adv_to(26);  chk_small("s_e26", 25, 0, 1, 0, 0, 0);
    adv_to(27);  chk_small("s_e27", 26, 0, 0, 0, 0, 0);
    adv_to(33);  chk_small("s_e33", 0, 1, 0, 0, 1, 0);
    adv_to(257); chk_small("s_e257", 0, 8, 0, 0, 0, 0);
    adv_to(320); chk_small("s_e320", 31, 9, 0, 0, 0, 0);
    adv_to(321); chk_small("s_e321", 0, 10, 0, 1, 0, 0);
    adv_to(416); chk_small("s_e416", 31, 12, 0, 1, 0, 0);
    adv_to(417); chk_small("s_e417", 0, 13, 0, 0, 0, 0);

    fs_cnt = 0;
    while (edge_n < 513) begin
      tick();
      if (s_fs === 1'b1) fs_cnt++;
      if (edge_n == 512) chk_small("s_e512", 31, 15, 0, 0, 0, 0);
    end
    chk("s_fs_per_frame", 32'(fs_cnt), 1);
    chk_small("s_e513", 0, 0, 0, 0, 1, 1);
`ifdef VTG_FRAME_COUNT_EN
    chk("s_e513.fc", 32'(s_fc), 1);
`endif

    // Hold right after frame_start: position frozen, frame_start forced low.
    en = 1'b0;
    repeat (20) @(posedge pixel_clk);
    #1;
    chk_small("hold_fs", 0, 0, 0, 0, 1, 0);
    en = 1'b1;
    tick();
    chk_small("s_e514", 1, 0, 0, 0, 1, 0);

    // Hold inside hsync.
    adv_to(535);
    chk_small("s_e535", 22, 0, 1, 0, 0, 0);
    en = 1'b0;
    repeat (20) @(posedge pixel_clk);
    #1;
    chk_small("hold_sync", 22, 0, 1, 0, 0, 0);
    en = 1'b1;
    tick();
    chk_small("resume", 23, 0, 1, 0, 0, 0);

    // Mid-frame reset at (12,5), then restart as from power-up.
    adv_to(685);
    chk_small("s_e685", 12, 5, 0, 0, 1, 0);
    reset = 1'b1;
    en    = 1'b0;
    tick();
    chk_small("mid_rst", 0, 0, 0, 0, 0, 0);
`ifdef VTG_FRAME_COUNT_EN
    chk("mid_rst.fc", 32'(s_fc), 0);
`endif
    reset = 1'b0;
    tick();
    chk_small("idle_after_rst", 0, 0, 0, 0, 0, 0);
    en     = 1'b1;
    edge_n = 0;
    tick();
    chk_small("restart", 0, 0, 0, 0, 1, 1);
`ifdef VTG_FRAME_COUNT_EN
    chk("restart.fc", 32'(s_fc), 0);
`endif
    tick();
    chk_small("restart_e2", 1, 0, 0, 0, 1, 0);
    adv_to(513);
    chk_small("restart_e513", 0, 0, 0, 0, 1, 1);
`ifdef VTG_FRAME_COUNT_EN
    chk("restart_e513.fc", 32'(s_fc), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Generates the raster timing that drives the display path: hsync, vsync, data-enable and the current pixel coordinates for a fixed video mode (720p60 by default). It is the transmitting end of the sync interface that the camera/ray stage consumes. All pixel-rate blocks derive their position from this block's hsync/vsync and coordinate outputs. One clock domain, `pixel_clk`.

## Interface
- hWidth, 1280, active pixels per line
- hFrontPorch, 72, pixels between active end and hsync
- hSyncWidth, 80, hsync pulse width in pixels
- hBackPorch, 216, pixels between hsync end and next line
- vWidth, 720, active lines per frame
- vFrontPorch, 3, lines between active end and vsync
- vSyncWidth, 5, vsync pulse width in lines
- vBackPorch, 22, lines between vsync end and next frame
- pixel_clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  pixel advance enable; low holds all state and outputs
- hsync  out  1  active-high horizontal sync
- vsync  out  1  active-high vertical sync
- de  out  1  high when (hCount, vCount) is inside the active area
- hCount  out  $clog2(hTotal)  current column, hTotal = 1648
- vCount  out  $clog2(vTotal)  current line, vTotal = 750
- frame_start  out  1  one-cycle pulse when (0,0) is presented

## Operation
- Internal flag `running`; cleared by reset, set on first `en` edge after reset.
- Reset: hCount=0, vCount=0, hsync=0, vsync=0, de=0, frame_start=0, running=0.
- First enabled edge with reset low: presents (0,0), de=1, frame_start=1, running=1.
- Each later enabled edge: hCount+1; at hTotal-1 wraps to 0 and vCount+1; vCount at vTotal-1 wraps to 0.
- Horizontal regions by hCount: ACTIVE [0,hWidth-1], FRONT [1280,1351], SYNC [1352,1431], BACK [1432,1647].
- Vertical regions by vCount: ACTIVE [0,719], FRONT [720,722], SYNC [723,727], BACK [728,749].
- hsync = H region SYNC; vsync = V region SYNC (vsync changes only when hCount=0); de = H ACTIVE and V ACTIVE.
- frame_start high only for the edge presenting (0,0); low on all others, including held cycles.
- Rising edge of hsync is presented with hCount = hWidth+hFrontPorch; rising edge of vsync with vCount = vWidth+vFrontPorch, hCount=0 (the positions downstream counters resync to).

## Timing
- All outputs registered and mutually aligned: the hCount/vCount on the port are the position the sync/de bits describe.
- Latency from reset deassert to first valid pixel: one enabled edge.
- en low: every output holds its value; frame_start forced 0.
- reset high mid-frame: next edge returns to reset values regardless of en; restart proceeds as from power-up.
- reset and en both high: reset wins.

## Configuration
- `VTG_FRAME_COUNT_EN` defined: extra output frame_count [15:0], reset 0, increments on every frame_start after the first, wraps 65535 -> 0.
- Not defined: port and counter absent; all other behaviour identical.

## Structure
- Package `video_timing`: `region_t` enum {ACTIVE, FRONT, SYNC, BACK}, 720p default constants, hTotal/vTotal derivation.
- Sub-module `timing_axis_counter`: parameterised by width/front/sync/back, inputs step and reset, outputs count, region, wrap; instantiated for h (step = en & running) and v (step = h wrap).
- Top handles `running`, output registers and frame_start.

## Test plan
- Reset held 10 cycles -> all outputs 0; first en edge -> hCount=0, vCount=0, de=1, frame_start=1.
- Free run -> hsync rises on edge 1353 (hCount=1352), falls on edge 1433; de falls at hCount=1280.
- Free run -> vsync rises on edge 1191505 (vCount=723, hCount=0), lasts 5*1648 edges.
- Free run -> frame_start again on edge 1236001 at (0,0), exactly once per frame.
- en low 20 cycles at hCount=500 -> all outputs frozen, frame_start 0; resumes at 501.
- Reset at (800,400) -> outputs zero next edge; restart as power-up; with `VTG_FRAME_COUNT_EN`, frame_count=0 then 1 after second frame_start.
